// File: rtl/oled_cmd_sequencer.sv
// Purpose: OLED power-up sequencer: timed panel hard reset, then plays SEQ_LEN ROM entries to the SPI byte writer.
// Latency: START accepted at edge T -> WRITE_START with DATA/DC from edge T+2; 2 cycles + writer latency per entry (+WAIT_CYCLES if flagged).
// Backpressure: one entry in flight; WRITE_START/DATA/DC are held until WRITE_DONE, entries are never dropped or skipped.
//
// Ports:
//   CLK, RST_N            clock (rising edge) and asynchronous active-low reset
//   START / DONE / BUSY   run request (level), sticky completion, run in progress
//   ROM_ADDR / ROM_DATA   registered ROM address; entry {wait, d/c, byte} valid 1 cycle later
//   WRITE_START / WRITE_DONE / DATA / DC   SPI byte writer handshake and payload
//   RST_OLED              panel hard reset, active low
module oled_cmd_sequencer #(
  parameter int RST_LOW_CYCLES  = 1000000,
  parameter int RST_WAIT_CYCLES = 1000000,
  parameter int SEQ_LEN         = 9,
  parameter int WAIT_CYCLES     = 100000,
  parameter int CNT_W           = 24,
  parameter int ADDR_W          = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              DONE,
  output logic              BUSY,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [9:0]        ROM_DATA,
  output logic              WRITE_START,
  input  logic              WRITE_DONE,
  output logic [7:0]        DATA,
  output logic              DC,
  output logic              RST_OLED
);

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DELAY,
    S_FIN
  } state_t;

  // Terminal counts. The settling wait is measured from the RST_OLED rising
  // edge to the earliest edge on which IDLE can accept START, so the
  // RST_WAIT state itself lasts one cycle less than RST_WAIT_CYCLES; with a
  // one-cycle wait the RST_WAIT state is skipped entirely.
  localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SET_LAST  = CNT_W'((RST_WAIT_CYCLES > 1) ? (RST_WAIT_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0]  DLY_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SEQ_LEN - 1);
  localparam bit                SKIP_WAIT = (RST_WAIT_CYCLES <= 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pending;    // START seen before the panel was ready
  logic             wait_flag;  // current entry asks for a post-write delay
  logic             last_entry;

  assign last_entry = (ROM_ADDR == ADDR_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_RST_LOW;
      cnt         <= '0;
      pending     <= 1'b0;
      wait_flag   <= 1'b0;
      RST_OLED    <= 1'b0;
      WRITE_START <= 1'b0;
      DATA        <= 8'h00;
      DC          <= 1'b0;
      DONE        <= 1'b0;
      BUSY        <= 1'b0;
      ROM_ADDR    <= '0;
    end else begin
      case (state)
        S_RST_LOW: begin
          if (START) pending <= 1'b1;
          if (cnt >= LOW_LAST) begin
            cnt      <= '0;
            RST_OLED <= 1'b1;
            state    <= SKIP_WAIT ? S_IDLE : S_RST_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RST_WAIT: begin
          if (START) pending <= 1'b1;
          if (cnt >= SET_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_IDLE: begin
          if (START || pending) begin
            pending  <= 1'b0;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            ROM_ADDR <= '0;
            state    <= S_FETCH;
          end
        end

        // Address reaches the ROM on this edge; its output is sampled on
        // the first ISSUE edge.
        S_FETCH: state <= S_ISSUE;

        S_ISSUE: begin
          if (!WRITE_START) begin
            DATA        <= ROM_DATA[7:0];
            DC          <= ROM_DATA[8];
            wait_flag   <= ROM_DATA[9];
            WRITE_START <= 1'b1;
          end else if (WRITE_DONE) begin
            WRITE_START <= 1'b0;
            if (wait_flag) begin
              cnt   <= '0;
              state <= S_DELAY;
            end else if (last_entry) begin
              state <= S_FIN;
            end else begin
              ROM_ADDR <= ROM_ADDR + ADDR_W'(1);
              state    <= S_FETCH;
            end
          end
        end

        S_DELAY: begin
          if (cnt >= DLY_LAST) begin
            cnt <= '0;
            if (last_entry) begin
              state <= S_FIN;
            end else begin
              ROM_ADDR <= ROM_ADDR + ADDR_W'(1);
              state    <= S_FETCH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_FIN: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        // Unused encoding: park in IDLE, the panel is already out of reset.
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
